// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with prescaler, one-shot or
// auto-reload mode, pause and abort.
//
// Parameters
//   W      width of the count value (>= 2)
//   PRESC  clk cycles per count tick (>= 1)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous, active-high reset
//   load_valid  load request
//   load_ready  timer idle and able to accept a load (combinational)
//   load_val    start value, sampled on load acceptance
//   periodic    1 = auto-reload, 0 = one-shot; sampled on load acceptance
//   pause       level; freezes count and prescaler while high
//   abort       level; cancels a running timer, blocks loads while high
//   cnt         remaining ticks (registered)
//   busy        timer running or paused
//   expire      registered one-cycle pulse on expiry
module down_timer #(
    parameter int W     = 16,
    parameter int PRESC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_val,
    input  logic         periodic,
    input  logic         pause,
    input  logic         abort,
    output logic [W-1:0] cnt,
    output logic         busy,
    output logic         expire
);

    localparam int PW = $clog2(PRESC) + 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [W-1:0]  CNT_ONE    = W'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_reload;
    logic          r_periodic;
    logic [PW-1:0] r_presc;
    logic          r_expire;
    logic          w_tick;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign load_ready = (r_state == S_IDLE) && !abort;
    assign busy       = (r_state != S_IDLE);
    assign cnt        = r_cnt;
    assign expire     = r_expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_presc    <= '0;
            r_expire   <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_valid && !abort) begin
                        r_cnt      <= load_val;
                        r_reload   <= load_val;
                        r_periodic <= periodic;
                        r_presc    <= '0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN, S_PAUSED: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_presc <= '0;
                    end else if (r_cnt == '0) begin
                        // Zero-length load: expire on the edge after
                        // acceptance, independent of prescaler and mode.
                        r_expire <= 1'b1;
                        r_state  <= S_IDLE;
                        r_presc  <= '0;
                    end else if (pause) begin
                        r_state <= S_PAUSED;
                    end else begin
                        // The edge that leaves PAUSED is a normal run edge,
                        // so a pause of N cycles delays expiry by exactly N.
                        r_state <= S_RUN;
                        if (w_tick) begin
                            r_presc <= '0;
                            if (r_cnt > CNT_ONE) begin
                                r_cnt <= r_cnt - CNT_ONE;
                            end else if (r_periodic) begin
                                r_cnt    <= r_reload;
                                r_expire <= 1'b1;
                            end else begin
                                r_cnt    <= '0;
                                r_expire <= 1'b1;
                                r_state  <= S_IDLE;
                            end
                        end else begin
                            r_presc <= r_presc + PRESC_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_presc <= '0;
                end
            endcase
        end
    end

endmodule
